// File: rtl/pixel_packer.sv
// Packs 24-bit RGB pixels into 32-bit AXI4-Stream words (4 pixels -> 3 words)
// with frame-start on tuser, line-end on tlast and a frame_done pulse.
module pixel_packer #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tuser,
    output logic        out_stream_tlast,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready,
    output logic        frame_done
);
    localparam int XW = $clog2(X_SIZE);
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

    phase_t        phase_q, phase_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [23:0]   res_q, res_d;
    logic [31:0]   tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tuser_q, tuser_d;
    logic          tlast_q, tlast_d;
    logic          fend_q, fend_d;
    logic          fdone_q, fdone_d;
    logic          accept;
    logic          emit;
    logic [31:0]   word;

    assign in_ready = !tvalid_q || out_stream_tready;
    assign accept   = in_valid && in_ready;

    // Residual bytes are kept in stream order starting at [7:0].
    always_comb begin
        phase_d = phase_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        emit    = 1'b0;
        word    = '0;
        if (accept) begin
            case (phase_q)
                PH0: begin
                    res_d   = {in_b, in_g, in_r};
                    phase_d = PH1;
                end
                PH1: begin
                    word    = {in_r, res_q[23:0]};
                    res_d   = {8'h00, in_b, in_g};
                    emit    = 1'b1;
                    phase_d = PH2;
                end
                PH2: begin
                    word    = {in_g, in_r, res_q[15:0]};
                    res_d   = {16'h0000, in_b};
                    emit    = 1'b1;
                    phase_d = PH3;
                end
                default: begin
                    word    = {in_b, in_g, in_r, res_q[7:0]};
                    res_d   = '0;
                    emit    = 1'b1;
                    phase_d = PH0;
                end
            endcase
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_comb begin
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        fend_d   = fend_q;
        tvalid_d = tvalid_q && !out_stream_tready;
        fdone_d  = tvalid_q && out_stream_tready && fend_q;
        if (emit) begin
            tdata_d  = word;
            tvalid_d = 1'b1;
            tuser_d  = (phase_q == PH1) && (x_q == XW'(1)) && (y_q == '0);
            tlast_d  = (phase_q == PH3) && (x_q == X_LAST);
            fend_d   = (phase_q == PH3) && (x_q == X_LAST) && (y_q == Y_LAST);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            phase_q  <= PH0;
            x_q      <= '0;
            y_q      <= '0;
            res_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            fend_q   <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            x_q      <= x_d;
            y_q      <= y_d;
            res_q    <= res_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            fend_q   <= fend_d;
            fdone_q  <= fdone_d;
        end
    end

    assign out_stream_tdata  = tdata_q;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tuser  = tuser_q;
    assign out_stream_tlast  = tlast_q;
    assign out_stream_tvalid = tvalid_q;
    assign frame_done        = fdone_q;

endmodule

// File: doc/pixel_packer.md
# pixel_packer

Receives one 24-bit RGB pixel per handshake from the pixel buffer stage and packs the byte stream into 32-bit AXI4-Stream words for the video DMA, four pixels per three words. Generates frame-start (`tuser`) on the first word of each frame and line-end (`tlast`) on the last word of each line. It sits between the core-merging pixel buffer and the stream output port of the ray tracer.

## Interface
Parameters:
- `X_SIZE`, 640: pixels per line. Must be a multiple of 4 and at least 4.
- `Y_SIZE`, 480: lines per frame. Must be at least 1.

Ports:
- `aclk`  in  1  clock; all logic on rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `in_r`, `in_g`, `in_b`  in  8 each  pixel colour components.
- `in_valid`  in  1  pixel present this cycle.
- `in_ready`  out  1  packer accepts a pixel this cycle.
- `out_stream_tdata`  out  32  packed bytes; the first byte in stream order is at [7:0].
- `out_stream_tkeep`  out  4  constant 4'hF.
- `out_stream_tuser`  out  1  start of frame.
- `out_stream_tlast`  out  1  end of line.
- `out_stream_tvalid`  out  1  output word valid.
- `out_stream_tready`  in  1  downstream accepts the word.
- `frame_done`  out  1  one-cycle pulse when the last word of a frame is accepted.

## Operation
- **Pixel accept:** a pixel is accepted when `in_valid && in_ready`.
  - `in_ready = !out_stream_tvalid || out_stream_tready`.
  - `in_ready` must not depend on `in_valid`. The upstream stage drives valid combinationally from ready.
- **Byte order:** per pixel, bytes are in the order r, g, b.
- **Phase counter:** 2 bits (0..3), increments on each accept and wraps 3→0.
- **Per-phase action on accept:**
  - Phase 0: store r0, g0, b0 in the residual register. No word is emitted.
  - Phase 1: emit word0 = {r1, b0, g0, r0}. Store g1, b1.
  - Phase 2: emit word1 = {g2, r2, b1, g1}. Store b2.
  - Phase 3: emit word2 = {b3, g3, r3, b2}.
- **Output register:**
  - Loaded when a word is emitted.
  - Holds data, `tuser` and `tlast` stable while `tvalid && !tready`.
  - `tvalid` clears on `tready` unless a new word is loaded in the same cycle.
- **Position counters:**
  - `x` counts 0..X_SIZE-1 and `y` counts 0..Y_SIZE-1. Both advance on pixel accept.
  - `x` wraps to 0 and increments `y` after X_SIZE-1.
  - `y` wraps to 0 after Y_SIZE-1.
- **Sideband bits:**
  - `tuser` = 1 on the word containing pixel (0,0), i.e. the phase-1 word at x=1, y=0.
  - `tlast` = 1 on the phase-3 word where x=X_SIZE-1.
- **frame_done:** asserted for one cycle on the handshake (`tvalid && tready`) of the word with `tlast` set and y=Y_SIZE-1. That word is the frame's last word.
- **Reset (async, active-high):**
  - Phase, x, y, the residual register, `tvalid`, `tuser`, `tlast`, `tdata` and `frame_done` all clear to 0.
  - `in_ready` therefore reads 1 during and after reset.
  - Reset mid-frame discards any partial word. The next accepted pixel is treated as (0,0).

## Timing
- **Latency:** `tvalid` rises on the cycle after the accept that completes a word.
- **Throughput:** one pixel per cycle sustained while `tready` is high. Output averages 3 words per 4 cycles.
- **Back-pressure:** while `tvalid && !tready`, `in_ready` = 0 and no pixel is accepted.
- **Simultaneous events:** drain of the old word and load of a new word in the same cycle keep `tvalid` = 1 with the new data. No bubble is allowed.
- **Phase-0 accepts:** these never load the output register. A held word stays held.
- **frame_done:** registered; asserted in the cycle after the final handshake.

## Test plan
All scenarios use X_SIZE=8, Y_SIZE=2 unless stated.
- **Packing:** pixels (01,02,03), (04,05,06), (07,08,09), (0A,0B,0C) with `tready`=1 → words 0x04030201, 0x08070605, 0x0C0B0A09. The first word has `tuser`=1.
- **Full frame:** 16 pixels, back-to-back, `tready`=1 → 12 words.
  - `tlast` on words 6 and 12 only.
  - `tuser` on word 1 only.
  - `frame_done` pulses once, one cycle after word 12.
  - A second frame repeats identically.
- **Back-pressure:** `tready`=0 for 5 cycles after word0 is loaded → `in_ready`=0 and `tdata`/`tuser` stable throughout. Then raise `tready` → stream resumes with no lost or duplicated bytes.
- **Random stall:** random `in_valid` and random `tready` over 3 frames → output byte stream equals input r,g,b stream in order, and the `tlast` count is 6.
- **Reset mid-frame:** assert `areset` after 6 pixels → all outputs 0 immediately. After release, the next pixel (11,22,33) starts a new frame and its word has `tuser`=1.
- **Single line:** X_SIZE=4, Y_SIZE=1, 4 pixels → 3 words. The last word has `tlast`=1 and `frame_done` pulses.
